mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 2-to-1 data selector. Shares one registered output channel between two valid/ready requesters, X and Y. Each grant is held for a bounded burst of beats. The block generates the select S internally, routes data through a `behav_mux` instance, and registers the result. It sits between two producers and a single downstream consumer.

---
 rtl/arb_pkg.sv | 13 +
 rtl/behav_mux.sv | 13 +
 rtl/mux_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the two-requester round-robin output arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_X = 2'd1,
      GNT_Y = 2'd2
   } arb_state_t;

   localparam logic SEL_X = 1'b0;
   localparam logic SEL_Y = 1'b1;

endpackage

// File: rtl/behav_mux.sv
// Plain 2-to-1 data selector: sel = 0 passes a, sel = 1 passes b.
module behav_mux #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter sharing one registered valid/ready output between
// requesters X and Y; the grant rotates after BURST beats or when valid drops.
//
// state | meaning
// IDLE  | no grant held; arbitrate next edge, tie goes to the one not served last
// GNT_X | X owns the output slot until BURST beats or XV drops
// GNT_Y | Y owns the output slot until BURST beats or YV drops
module mux_rr_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int BURST = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] X,
   input  logic             XV,
   output logic             XR,
   input  logic [WIDTH-1:0] Y,
   input  logic             YV,
   output logic             YR,
   output logic [WIDTH-1:0] O,
   output logic             OV,
   input  logic             OR,
   output logic             S
);

   localparam logic [3:0] BURST_CNT = 4'(BURST);

   arb_state_t       state, state_n;
   logic             last, last_n;
   logic [3:0]       cnt, cnt_n;
   logic [3:0]       cnt_inc;
   logic             ld;
   logic             take_x, take_y, xfer;
   logic [WIDTH-1:0] mux_out;

   assign ld      = !OV || OR;
   assign S       = (state == GNT_Y) ? SEL_Y : SEL_X;
   assign XR      = ld && (state == GNT_X);
   assign YR      = ld && (state == GNT_Y);
   assign take_x  = XV && XR;
   assign take_y  = YV && YR;
   assign xfer    = take_x || take_y;
   assign cnt_inc = cnt + 4'd1;

   behav_mux #(.WIDTH(WIDTH)) u_mux (
      .a   (X),
      .b   (Y),
      .sel (S),
      .y   (mux_out)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         last  <= SEL_Y;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         last  <= last_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      last_n  = last;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (XV && YV)
               state_n = (last == SEL_X) ? GNT_Y : GNT_X;
            else if (XV)
               state_n = GNT_X;
            else if (YV)
               state_n = GNT_Y;
         end
         GNT_X: begin
            if (!XV || (take_x && cnt_inc == BURST_CNT)) begin
               last_n  = SEL_X;
               cnt_n   = 4'd0;
               state_n = YV ? GNT_Y : IDLE;
            end else if (take_x) begin
               cnt_n = cnt_inc;
            end
         end
         GNT_Y: begin
            if (!YV || (take_y && cnt_inc == BURST_CNT)) begin
               last_n  = SEL_Y;
               cnt_n   = 4'd0;
               state_n = XV ? GNT_X : IDLE;
            end else if (take_y) begin
               cnt_n = cnt_inc;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A new beat may overwrite O in the same cycle the old one is consumed.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         O  <= '0;
         OV <= 1'b0;
      end else if (xfer) begin
         O  <= mux_out;
         OV <= 1'b1;
      end else if (OV && OR) begin
         OV <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter with a behavioural model
// and an output scoreboard drained by an independent monitor.
module tb_mux_rr_arbiter;

   localparam int WIDTH = 2;
   localparam int BURST = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] x = '0, y = '0;
   logic             xv = 1'b0, yv = 1'b0;
   logic             xr, yr;
   logic [WIDTH-1:0] o;
   logic             ov;
   logic             or_i = 1'b0;
   logic             s;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] sb_q[$];

   // owner: 0 = nobody, 1 = X, 2 = Y; last: 0 = X served last, 1 = Y
   int               m_owner;
   int               m_beats;
   int               m_last;
   bit               m_ov;
   logic [WIDTH-1:0] m_o;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
      .CLK (clk),
      .RST (rst),
      .X   (x),
      .XV  (xv),
      .XR  (xr),
      .Y   (y),
      .YV  (yv),
      .YR  (yr),
      .O   (o),
      .OV  (ov),
      .OR  (or_i),
      .S   (s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_beats = 0;
      m_last  = 1;
      m_ov    = 1'b0;
      m_o     = '0;
      sb_q.delete();
   endtask

   // One clock cycle: drive at posedge+1, check and advance the model at negedge.
   task automatic cycle(input bit vx, input bit vy, input logic [WIDTH-1:0] dx,
                        input logic [WIDTH-1:0] dy, input bit r,
                        output bit acc_x, output bit acc_y);
      bit ld, exr, eyr;
      xv = vx; yv = vy; x = dx; y = dy; or_i = r;
      @(negedge clk);
      ld  = !m_ov || r;
      exr = ld && (m_owner == 1);
      eyr = ld && (m_owner == 2);
      chk("XR", xr, exr);
      chk("YR", yr, eyr);
      chk("S", s, m_owner == 2);
      chk("OV", ov, m_ov);
      if (m_ov) chk("O_held", o, m_o);
      acc_x = vx && exr;
      acc_y = vy && eyr;
      if (acc_x || acc_y) begin
         m_o  = acc_x ? dx : dy;
         m_ov = 1'b1;
         sb_q.push_back(m_o);
      end else if (m_ov && r) begin
         m_ov = 1'b0;
      end
      case (m_owner)
         0: begin
            if (vx && vy)      m_owner = (m_last == 0) ? 2 : 1;
            else if (vx)       m_owner = 1;
            else if (vy)       m_owner = 2;
         end
         1: begin
            if (!vx || (acc_x && m_beats + 1 == BURST)) begin
               m_last = 0; m_beats = 0; m_owner = vy ? 2 : 0;
            end else if (acc_x) m_beats++;
         end
         default: begin
            if (!vy || (acc_y && m_beats + 1 == BURST)) begin
               m_last = 1; m_beats = 0; m_owner = vx ? 1 : 0;
            end else if (acc_y) m_beats++;
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   // Monitor: a beat leaves the output slot at the edge after OV & OR is seen.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && ov && or_i) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_pop actual=unexpected_beat(%0h) required=no_beat t=%0t", o, $time);
            end else begin
               logic [WIDTH-1:0] e;
               e = sb_q.pop_front();
               if (o !== e) begin
                  failures++;
                  $display("FAIL sb_O actual=%0h required=%0h t=%0t", o, e, $time);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ax, ay;
      int n;
      logic [WIDTH-1:0] dx, dy;
      bit vx, vy;

      // Reset held with both requesters valid
      xv = 1'b1; yv = 1'b1; x = 2'd3; y = 2'd2; or_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_O", o, 0);
      chk("rst_OV", ov, 0);
      chk("rst_XR", xr, 0);
      chk("rst_YR", yr, 0);
      chk("rst_S", s, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();

      cycle(1, 1, 2'd3, 2'd2, 1, ax, ay);
      cycle(1, 1, 2'd3, 2'd2, 1, ax, ay);
      chk("tie_first_X", ax, 1);

      // Single requester X: bubble through IDLE after each burst
      for (int i = 0; i < 12; i++) cycle(1, 0, 2'd3, 2'd0, 1, ax, ay);

      // Contention with full throughput
      for (int i = 0; i < 14; i++) cycle(1, 1, 2'd1, 2'd2, 1, ax, ay);

      // Backpressure mid-burst
      for (int i = 0; i < 2; i++) cycle(1, 1, 2'd1, 2'd2, 1, ax, ay);
      for (int i = 0; i < 3; i++) cycle(1, 1, 2'd1, 2'd2, 0, ax, ay);
      for (int i = 0; i < 8; i++) cycle(1, 1, 2'd1, 2'd2, 1, ax, ay);

      // Early release of Y after 2 beats
      n = 0;
      while (!(m_owner == 2 && m_beats == 2) && n < 20) begin
         cycle(1, 1, 2'd1, 2'd2, 1, ax, ay);
         n++;
      end
      chk("early_reach", n < 20, 1);
      cycle(1, 0, 2'd1, 2'd2, 1, ax, ay);
      chk("early_no_beat", ax | ay, 0);
      cycle(1, 0, 2'd1, 2'd2, 1, ax, ay);
      chk("early_X_taken", ax, 1);
      for (int i = 0; i < 4; i++) cycle(1, 1, 2'd1, 2'd2, 1, ax, ay);

      // Asynchronous reset during a Y grant with a beat in O
      n = 0;
      while (!(m_owner == 2 && m_ov) && n < 20) begin
         cycle(1, 1, 2'd1, 2'd2, 1, ax, ay);
         n++;
      end
      chk("arst_reach", n < 20, 1);
      #2;
      chk("arst_pre_YR", yr, 1);
      chk("arst_pre_OV", ov, 1);
      rst = 1'b1;
      #1;
      chk("arst_OV", ov, 0);
      chk("arst_YR", yr, 0);
      chk("arst_S", s, 0);
      chk("arst_O", o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();

      // Randomized traffic; data held while valid and not yet accepted
      vx = 1'b0; vy = 1'b0; dx = '0; dy = '0; ax = 1'b0; ay = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (!(vx && !ax)) dx = WIDTH'($urandom);
         if (!(vy && !ay)) dy = WIDTH'($urandom);
         vx = ($urandom_range(0, 9) < 7);
         vy = ($urandom_range(0, 9) < 6);
         cycle(vx, vy, dx, dy, ($urandom_range(0, 3) != 0), ax, ay);
      end

      for (int i = 0; i < 6; i++) cycle(0, 0, 2'd0, 2'd0, 1, ax, ay);
      chk("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
